// File: rtl/posit_encoder_pipe.sv
// Two-stage posit packer: regime/exp/frac assembly with guard/sticky extraction
// in S1, round-to-nearest-even, saturation and two's-complement sign in S2.
module posit_encoder_pipe #(
  parameter int unsigned N      = 16,
  parameter int unsigned ES     = 1,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned KW     = $clog2(N) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [KW-1:0]     in_k,
  input  logic [ES-1:0]     in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_is_zero,
  input  logic              in_is_nar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_posit
);

  localparam int unsigned EF = ES + FRAC_W;
  // Room for the longest unsaturated regime plus exp/frac without losing bits.
  localparam int unsigned SW = N + EF + 2;
  localparam int unsigned BW = N - 1;

  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic          sign;
    logic          is_nar;
    logic          is_zero;
    logic          sat_max;
    logic          sat_min;
    logic [BW-1:0] body;
    logic          guard;
    logic          sticky;
  } s1_t;

  logic          k_neg;
  logic [KW-1:0] k_mag;
  logic [KW-1:0] shamt;
  logic [SW-1:0] base;
  logic [SW-1:0] shifted;
  s1_t           s1_d;
  s1_t           s1_q;
  logic          s1_valid_q;

  logic          up;
  logic [N-1:0]  mag_sum;
  logic [N-1:0]  mag;
  logic [N-1:0]  posit_d;
  logic [N-1:0]  posit_q;
  logic          s2_valid_q;

  logic          s2_load;
  logic          s1_adv;

  // Handshake: S2 loads when empty or drained; S1 advances when empty or S2 loads.
  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_load;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_posit = posit_q;

  // S1 assembly: an arithmetic shift of "10"/"01" + exp + frac produces the regime run.
  always_comb begin
    k_neg   = in_k[KW-1];
    // For k<0 the zero-run length minus one is -k-1 == ~k.
    k_mag   = k_neg ? ~in_k : in_k;
    shamt   = (k_mag > KW'(N - 2)) ? KW'(N - 2) : k_mag;
    base    = {(k_neg ? 2'b01 : 2'b10), in_exp, in_frac, {N{1'b0}}};
    shifted = $signed(base) >>> shamt;

    s1_d         = '0;
    s1_d.sign    = in_sign;
    s1_d.is_nar  = in_is_nar;
    s1_d.is_zero = in_is_zero;
    s1_d.sat_max = !k_neg && (k_mag > KW'(N - 2));
    s1_d.sat_min = k_neg && (k_mag > KW'(N - 3));
    s1_d.body    = shifted[SW-1 -: BW];
    s1_d.guard   = shifted[SW-N];
    s1_d.sticky  = |shifted[SW-N-1:0];
  end

  // S1 register: captures the assembled body/guard/sticky on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // S2 rounding, saturation, sign and specials.
  always_comb begin
    up      = s1_q.guard & (s1_q.body[0] | s1_q.sticky);
    mag_sum = {1'b0, s1_q.body} + N'(up);
    mag     = mag_sum;
    if (mag_sum[N-1] || s1_q.sat_max) begin
      mag = MAXPOS;
    end else if ((mag_sum == '0) || s1_q.sat_min) begin
      mag = MINPOS;
    end
    posit_d = s1_q.sign ? (~mag + N'(1)) : mag;
    if (s1_q.is_nar) begin
      posit_d = NAR;
    end else if (s1_q.is_zero) begin
      posit_d = '0;
    end
  end

  // S2 register: output stage, holds while stalled by out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      posit_q    <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        posit_q <= posit_d;
      end
    end
  end

endmodule

// File: doc/posit_encoder_pipe.md
Name: posit_encoder_pipe

Overview:
- Pipelined posit packer: the encode-side counterpart of the leading-zero-count regime decoder.
- Takes an unpacked posit (sign, regime value k, exponent, fraction, special flags) and emits the N-bit posit.
- Builds the regime run from k, rounds to nearest even, saturates, and applies the two's-complement sign.
- Sits at the output of the PPU arithmetic core; valid/ready handshake on both sides.

Parameters:
- N, 16, posit width in bits (>= 8).
- ES, 1, exponent field width.
- FRAC_W, 16, input fraction width, hidden bit excluded, MSB-aligned.
- KW, $clog2(N)+2, width of signed regime input k.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign  in  1  sign of result.
- in_k  in  KW  signed regime value.
- in_exp  in  ES  exponent field.
- in_frac  in  FRAC_W  fraction bits after the hidden 1.
- in_is_zero  in  1  result is zero.
- in_is_nar  in  1  result is NaR; has priority over in_is_zero.
- out_valid  out  1  output posit valid.
- out_ready  in  1  downstream accepts.
- out_posit  out  N  encoded posit.

Behaviour:
- Reset: clears all stage valids. out_valid=0, out_posit=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight beats are discarded, never emitted.
- Handshake: a transfer occurs when valid && ready on a port.
- Pipeline: two register stages, S1 and S2; S2 drives the outputs.
- Latency: 2 cycles from the input transfer to out_valid with no stall.
- Throughput: 1 beat/cycle.
- Stage advance: S2 loads when it is empty or out_ready=1. S1 advances when it is empty or S2 loads.
- in_ready = !S1_valid || S2 loads. It is combinational from out_ready; in_valid does not feed it.
- While out_valid=1 and out_ready=0, out_posit and out_valid hold stable.
- With S1 and S2 both full and out_ready=0, in_ready=0.
- Beats are never dropped, duplicated or reordered.
- S1 assembly:
  - Regime: k>=0 gives (k+1) ones then a zero, length k+2. k<0 gives (-k) zeros then a one, length -k+1.
  - Concatenate regime, exp, frac, MSB first, after the sign position.
  - Keep the top N-1 bits as the magnitude body. The next bit is guard. The OR of all remaining bits is sticky; zero padding is used if the string is shorter.
  - Saturation flags: k > N-2 sets sat_max; k < -(N-2) sets sat_min.
  - Register body, guard, sticky, flags, sign.
- S2 rounding:
  - Round up iff guard && (body_lsb || sticky).
  - mag = {1'b0, body} + up.
  - If mag overflows to bit N-1, or sat_max: mag = maxpos = 0 followed by N-1 ones.
  - If mag == 0 or sat_min: mag = minpos = 1.
  - A non-zero input never encodes to 0 or NaR.
- S2 sign and specials:
  - out = sign ? (~mag + 1) : mag.
  - in_is_nar gives 1 followed by N-1 zeros. in_is_zero gives all zeros. In both cases all other fields are ignored.
- k = N-2 exactly: regime is all ones with no terminator; exp and frac are fully truncated into guard/sticky.

Test Plan (N=16, ES=1, FRAC_W=16):
- k=0, exp=0, frac=0, sign=0 -> 0x4000 two cycles later. Same with sign=1 -> 0xC000.
- k=0, exp=0: frac=0x0008 -> 0x4000 (tie, even). frac=0x0018 -> 0x4002 (tie, odd, round up). frac=0x0009 -> 0x4001 (sticky).
- k=20 -> 0x7FFF. k=-20 -> 0x0001. k=14, exp=1, frac=0xFFFF -> 0x7FFF (no rounding into NaR).
- in_is_nar=1 -> 0x8000. in_is_zero=1 -> 0x0000. Both set -> 0x8000.
- Back-to-back 1.0, 2.0 (k=0, exp=1 -> 0x5000), 4.0 (k=1 -> 0x6000), out_ready=0 for 5 cycles:
  - First two beats are accepted; in_ready=0 on the third.
  - out_posit holds 0x4000 throughout the stall.
  - Release gives 0x4000, 0x5000, 0x6000 in order, one per cycle.
- rst asserted with both stages full -> out_valid=0 next cycle. Neither beat appears after rst deasserts.
